// File: rtl/servo_cmd_sequencer_if.sv
// Byte-stream input and slewed-angle/status outputs of the servo command sequencer.
// The sequencer uses the slave modport; the UART side and bench use master.
interface servo_cmd_sequencer_if #(
  parameter int NUM_SERVO = 4
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [8*NUM_SERVO-1:0] angle_bus;
  logic                   busy;
  logic                   cmd_ok;
  logic                   frame_err;

  modport master (
    output rx_data, rx_valid,
    input  angle_bus, busy, cmd_ok, frame_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output angle_bus, busy, cmd_ok, frame_err
  );
endinterface

// File: rtl/servo_cmd_sequencer.sv
// Parses FF/id/angle/chk frames from a UART byte stream, holds a target per servo
// and slews each output angle toward its target by one degree per step tick.
module servo_cmd_sequencer #(
  parameter int NUM_SERVO     = 4,
  parameter int STEP_TICKS    = 500000,
  parameter int TIMEOUT_TICKS = 5000000,
  parameter int INIT_ANGLE    = 90,
  parameter int MAX_ANGLE     = 180
) (
  input  logic                   clk,
  input  logic                   reset,
  servo_cmd_sequencer_if.slave   bus
);

  localparam logic [7:0]  HDR       = 8'hFF;
  localparam logic [7:0]  INIT      = 8'(INIT_ANGLE);
  localparam logic [7:0]  MAXA      = 8'(MAX_ANGLE);
  localparam logic [7:0]  NSV       = 8'(NUM_SERVO);
  localparam logic [31:0] STEP_LAST = 32'(STEP_TICKS - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ID,
    WAIT_ANG,
    WAIT_CHK
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  id_q, id_d;
  logic [7:0]  ang_q, ang_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  target_q [NUM_SERVO];
  logic [7:0]  target_d [NUM_SERVO];
  logic [7:0]  angle_q  [NUM_SERVO];
  logic [7:0]  angle_d  [NUM_SERVO];
  logic        busy_q, busy_d;
  logic        cmd_ok_q, cmd_ok_d;
  logic        frame_err_q, frame_err_d;
  logic        tick;

  // Frame parser; a received byte always takes priority over a timeout expiring.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    ang_d       = ang_q;
    to_cnt_d    = to_cnt_q;
    target_d    = target_q;
    cmd_ok_d    = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
      if (bus.rx_valid && bus.rx_data == HDR) begin
        state_d = WAIT_ID;
      end
    end else if (bus.rx_valid) begin
      to_cnt_d = '0;
      if (bus.rx_data == HDR) begin
        frame_err_d = 1'b1;
        state_d     = WAIT_ID;
      end else begin
        case (state_q)
          WAIT_ID: begin
            id_d    = bus.rx_data;
            state_d = WAIT_ANG;
          end
          WAIT_ANG: begin
            ang_d   = bus.rx_data;
            state_d = WAIT_CHK;
          end
          WAIT_CHK: begin
            state_d = IDLE;
            if (id_q >= NSV || ang_q > MAXA || bus.rx_data != (id_q ^ ang_q)) begin
              frame_err_d = 1'b1;
            end else begin
              cmd_ok_d = 1'b1;
              for (int unsigned i = 0; i < NUM_SERVO; i++) begin
                if (id_q == 8'(i)) begin
                  target_d[i] = ang_q;
                end
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (to_cnt_q == TO_LAST) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
      to_cnt_d    = '0;
    end else begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  // Slew engine compares against the registered target, so a target written on a
  // tick cycle only influences the following tick.
  always_comb begin
    tick       = (tick_cnt_q == STEP_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 32'd1;
    angle_d    = angle_q;
    busy_d     = 1'b0;
    for (int unsigned i = 0; i < NUM_SERVO; i++) begin
      if (angle_q[i] != target_q[i]) begin
        busy_d = 1'b1;
      end
      if (tick) begin
        if (angle_q[i] < target_q[i]) begin
          angle_d[i] = angle_q[i] + 8'd1;
        end else if (angle_q[i] > target_q[i]) begin
          angle_d[i] = angle_q[i] - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= '0;
      ang_q       <= '0;
      to_cnt_q    <= '0;
      tick_cnt_q  <= '0;
      busy_q      <= 1'b0;
      cmd_ok_q    <= 1'b0;
      frame_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SERVO; i++) begin
        target_q[i] <= INIT;
        angle_q[i]  <= INIT;
      end
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      ang_q       <= ang_d;
      to_cnt_q    <= to_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      busy_q      <= busy_d;
      cmd_ok_q    <= cmd_ok_d;
      frame_err_q <= frame_err_d;
      target_q    <= target_d;
      angle_q     <= angle_d;
    end
  end

  always_comb begin
    bus.angle_bus = '0;
    for (int unsigned i = 0; i < NUM_SERVO; i++) begin
      bus.angle_bus[8*i +: 8] = angle_q[i];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.cmd_ok    = cmd_ok_q;
  assign bus.frame_err = frame_err_q;

endmodule
